// File: rtl/iram_fetch_arbiter_if.sv
// Bus bundle between the per-core fetch stages, the IRAM read port and the arbiter.
// The perf counter signals exist only when IFETCH_PERF_EN is defined.
interface iram_fetch_arbiter_if #(
    parameter int NUM_CORES = 16,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
);
    logic [NUM_CORES-1:0][1:0]        core_ctrl;
    logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0][DATA_W-1:0] core_instr;
    logic [NUM_CORES-1:0]             core_done;
    logic                             ram_rd_en;
    logic [ADDR_W-1:0]                ram_addr;
    logic [DATA_W-1:0]                ram_rdata;
    logic                             busy;
`ifdef IFETCH_PERF_EN
    logic [31:0]                      perf_fetches;
    logic [31:0]                      perf_stalls;
`endif

    modport slave (
        input  core_ctrl, core_addr, ram_rdata,
`ifdef IFETCH_PERF_EN
        output perf_fetches, perf_stalls,
`endif
        output core_instr, core_done, ram_rd_en, ram_addr, busy
    );

    modport master (
        output core_ctrl, core_addr, ram_rdata,
`ifdef IFETCH_PERF_EN
        input  perf_fetches, perf_stalls,
`endif
        input  core_instr, core_done, ram_rd_en, ram_addr, busy
    );
endinterface

// File: rtl/iram_fetch_arbiter.sv
// Round-robin arbiter sharing one registered IRAM read port among NUM_CORES cores.
// Optional macro IFETCH_PERF_EN adds saturating fetch/stall counters.

// Per-core result register: captures the RAM word and pulses done for one cycle.
module iram_fetch_lane #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              done_o
);
    logic [DATA_W-1:0] instr_q;
    logic              done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= cap_i;
            if (cap_i) instr_q <= rdata_i;
        end
    end

    assign instr_o = instr_q;
    assign done_o  = done_q;
endmodule

module iram_fetch_arbiter #(
    parameter int NUM_CORES   = 16,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    iram_fetch_arbiter_if.slave bus
);
    localparam int STAGES = RAM_LATENCY;
    localparam int IDX_W  = $clog2(NUM_CORES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CORES - 1);
    localparam logic [IDX_W:0]   NC_W = (IDX_W + 1)'(NUM_CORES);

    logic [NUM_CORES-1:0]             elig;
    logic [NUM_CORES-1:0]             gnt_oh;
    logic [NUM_CORES-1:0]             cap;
    logic [NUM_CORES-1:0]             inflight_q, inflight_d;
    logic [IDX_W-1:0]                 ptr_q, ptr_d;
    logic [IDX_W-1:0]                 gnt_id;
    logic                             gnt_vld;
    logic [IDX_W:0]                   sum;
    logic [IDX_W-1:0]                 idx;
    logic [STAGES:0]                  vld_pipe_q;
    logic [STAGES:0][IDX_W-1:0]       id_pipe_q;
    logic                             ram_rd_en_q;
    logic [ADDR_W-1:0]                ram_addr_q;
    logic                             busy_q;
    logic [NUM_CORES-1:0][DATA_W-1:0] instr_w;
    logic [NUM_CORES-1:0]             done_w;
    logic [DATA_W-1:0]                rdata_w;

    // Eligibility uses the registered mask, so a held request can't be re-granted
    // on the same edge its data returns.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CORES; i++)
            elig[i] = (bus.core_ctrl[i] == 2'd1) && !inflight_q[i];
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (sum >= NC_W) sum = sum - NC_W;
            idx = sum[IDX_W-1:0];
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        cap    = '0;
        if (gnt_vld) gnt_oh[gnt_id] = 1'b1;
        if (vld_pipe_q[STAGES]) cap[id_pipe_q[STAGES]] = 1'b1;
        inflight_d = (inflight_q & ~cap) | gnt_oh;
        ptr_d      = ptr_q;
        if (gnt_vld) ptr_d = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= '0;
            inflight_q  <= '0;
            vld_pipe_q  <= '0;
            id_pipe_q   <= '0;
            ram_rd_en_q <= 1'b0;
            ram_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            inflight_q  <= inflight_d;
            busy_q      <= |inflight_d;
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], gnt_vld};
            id_pipe_q   <= {id_pipe_q[STAGES-1:0], gnt_id};
            ram_rd_en_q <= gnt_vld;
            if (gnt_vld) ram_addr_q <= bus.core_addr[gnt_id];
        end
    end

    assign rdata_w = bus.ram_rdata;

    iram_fetch_lane #(.DATA_W(DATA_W)) u_lane [NUM_CORES-1:0] (
        .clock   (clock),
        .reset   (reset),
        .cap_i   (cap),
        .rdata_i (rdata_w),
        .instr_o (instr_w),
        .done_o  (done_w)
    );

    assign bus.core_instr = instr_w;
    assign bus.core_done  = done_w;
    assign bus.ram_rd_en  = ram_rd_en_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.busy       = busy_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetches_q, perf_stalls_q;
    logic        stall;

    assign stall = |(elig & ~gnt_oh);

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetches_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            if (gnt_vld && !(&perf_fetches_q)) perf_fetches_q <= perf_fetches_q + 32'd1;
            if (stall && !(&perf_stalls_q))    perf_stalls_q  <= perf_stalls_q + 32'd1;
        end
    end

    assign bus.perf_fetches = perf_fetches_q;
    assign bus.perf_stalls  = perf_stalls_q;
`endif
endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Scenario bench for iram_fetch_arbiter: a registered RAM model feeds the read port and
// a scoreboard queue of expected (core, word) pairs is retired by each done pulse.
module tb_iram_fetch_arbiter;
    localparam int NC = 16;

    typedef struct {
        int          id;
        logic [15:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];
    logic [15:0] mem [0:255];

    iram_fetch_arbiter_if #(.NUM_CORES(NC), .ADDR_W(16), .DATA_W(16)) bus ();

    iram_fetch_arbiter #(.NUM_CORES(NC), .ADDR_W(16), .DATA_W(16), .RAM_LATENCY(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // One-cycle registered RAM
    always @(posedge clock)
        if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_addr[7:0]];

    exp_t        me;
    logic [15:0] exp_done;
    always @(negedge clock) begin
        if (!reset && bus.core_done !== '0) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected_done done=%h expected none", bus.core_done);
            end else begin
                me = sb.pop_front();
                exp_done = '0;
                exp_done[me.id] = 1'b1;
                if (bus.core_done !== exp_done || bus.core_instr[me.id] !== me.data) begin
                    mismatched++;
                    $display("FAIL sb_done done=%h instr=%h expected done=%h instr=%h",
                             bus.core_done, bus.core_instr[me.id], exp_done, me.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.core_ctrl = '0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic push(input int id, input logic [15:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        bus.core_ctrl = '0;
        bus.core_addr = '0;
        reset = 1'b1;
        repeat (3) cyc();
        compared++;
        if (bus.core_done !== '0 || bus.ram_rd_en !== 1'b0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl done=%h rd_en=%b busy=%b expected 0/0/0",
                     bus.core_done, bus.ram_rd_en, bus.busy);
        end
        compared++;
        if (bus.ram_addr !== '0 || bus.core_instr !== '0) begin
            mismatched++;
            $display("FAIL reset_data ram_addr=%h instr0=%h expected 0", bus.ram_addr, bus.core_instr[0]);
        end
`ifdef IFETCH_PERF_EN
        compared++;
        if (bus.perf_fetches !== 32'd0 || bus.perf_stalls !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_perf fetches=%0d stalls=%0d expected 0/0", bus.perf_fetches, bus.perf_stalls);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_single();
        mem[5] = 16'h4008;
        bus.core_ctrl[3] = 2'd1;
        bus.core_addr[3] = 16'd5;
        push(3, 16'h4008);
        cyc();  // E0
        compared++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 16'd5 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_grant rd_en=%b addr=%h busy=%b expected 1/0005/1",
                     bus.ram_rd_en, bus.ram_addr, bus.busy);
        end
        bus.core_ctrl[3] = 2'd0;
        cyc();  // E1
        compared++;
        if (bus.ram_rd_en !== 1'b0 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_e1 rd_en=%b busy=%b expected 0/1", bus.ram_rd_en, bus.busy);
        end
        cyc();  // E2
        compared++;
        if (bus.core_done !== 16'h0008 || bus.core_instr[3] !== 16'h4008 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_done done=%h instr=%h busy=%b expected 0008/4008/0",
                     bus.core_done, bus.core_instr[3], bus.busy);
        end
        cyc();  // E3
        compared++;
        if (bus.core_done !== '0 || bus.core_instr[3] !== 16'h4008) begin
            mismatched++;
            $display("FAIL single_pulse done=%h instr=%h expected 0000/4008", bus.core_done, bus.core_instr[3]);
        end
    endtask

    task automatic test_all_cores();
        int bad;
        do_reset();
        for (int i = 0; i < NC; i++) begin
            mem[i] = 16'h0100 + 16'(i);
            bus.core_ctrl[i] = 2'd1;
            bus.core_addr[i] = 16'(i);
            push(i, 16'h0100 + 16'(i));
        end
        for (int k = 0; k < NC; k++) begin
            cyc();
            compared++;
            if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 16'(k)) begin
                mismatched++;
                $display("FAIL all_grant_%0d rd_en=%b addr=%h expected 1/%h", k, bus.ram_rd_en, bus.ram_addr, 16'(k));
            end
            bus.core_ctrl[k] = 2'd0;
        end
        cyc();
        compared++;
        if (bus.ram_rd_en !== 1'b0) begin
            mismatched++;
            $display("FAIL all_no_dup rd_en=%b expected 0", bus.ram_rd_en);
        end
        repeat (3) cyc();
        compared++;
        if (sb.size() != 0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL all_drain pending=%0d busy=%b expected 0/0", sb.size(), bus.busy);
        end
        bad = 0;
        for (int i = 0; i < NC; i++)
            if (bus.core_instr[i] !== 16'h0100 + 16'(i)) bad++;
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL all_instr wrong_slices=%0d expected 0", bad);
        end
    endtask

    task automatic test_rotation();
        int          order [3];
        logic [15:0] eaddr;
        order = '{14, 15, 2};
        for (int i = 0; i < NC; i++) mem[8'h20 + i] = 16'h2000 + 16'(i);
        bus.core_ctrl[13] = 2'd1;
        bus.core_addr[13] = 16'h002D;
        push(13, 16'h200D);
        cyc();
        compared++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 16'h002D) begin
            mismatched++;
            $display("FAIL rot_setup rd_en=%b addr=%h expected 1/002d", bus.ram_rd_en, bus.ram_addr);
        end
        bus.core_ctrl[13] = 2'd0;
        repeat (3) cyc();
        foreach (order[j]) begin
            bus.core_ctrl[order[j]] = 2'd1;
            bus.core_addr[order[j]] = 16'h0020 + 16'(order[j]);
            push(order[j], 16'h2000 + 16'(order[j]));
        end
        foreach (order[j]) begin
            cyc();
            eaddr = 16'h0020 + 16'(order[j]);
            compared++;
            if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== eaddr) begin
                mismatched++;
                $display("FAIL rot_grant_%0d rd_en=%b addr=%h expected 1/%h", j, bus.ram_rd_en, bus.ram_addr, eaddr);
            end
            bus.core_ctrl[order[j]] = 2'd0;
        end
        repeat (4) cyc();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL rot_drain pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int          nfetch;
        int          fcyc [2];
        logic [15:0] faddr [2];
        nfetch = 0;
        fcyc = '{-1, -1};
        faddr = '{16'hFFFF, 16'hFFFF};
        mem[9] = 16'h0909;
        mem[10] = 16'h0A0A;
        bus.core_ctrl[7] = 2'd1;
        bus.core_addr[7] = 16'd9;
        push(7, 16'h0909);
        push(7, 16'h0A0A);
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (bus.ram_rd_en === 1'b1) begin
                if (nfetch < 2) begin
                    fcyc[nfetch] = c;
                    faddr[nfetch] = bus.ram_addr;
                end
                nfetch++;
                if (nfetch == 2) bus.core_ctrl[7] = 2'd0;
            end
            if (bus.core_done[7] === 1'b1) bus.core_addr[7] = 16'd10;
        end
        compared++;
        if (nfetch != 2) begin
            mismatched++;
            $display("FAIL hold_count fetches=%0d expected 2", nfetch);
        end
        compared++;
        if (fcyc[0] != 0 || fcyc[1] != 3) begin
            mismatched++;
            $display("FAIL hold_spacing cycles=%0d,%0d expected 0,3", fcyc[0], fcyc[1]);
        end
        compared++;
        if (faddr[0] !== 16'd9 || faddr[1] !== 16'd10) begin
            mismatched++;
            $display("FAIL hold_addr addrs=%h,%h expected 0009,000a", faddr[0], faddr[1]);
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL hold_drain pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        mem[8'h31] = 16'hBEEF;
        mem[8'h32] = 16'h3232;
        bus.core_ctrl[1] = 2'd1;
        bus.core_addr[1] = 16'h0031;
        cyc();
        compared++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 16'h0031) begin
            mismatched++;
            $display("FAIL rmid_grant rd_en=%b addr=%h expected 1/0031", bus.ram_rd_en, bus.ram_addr);
        end
        reset = 1'b1;
        bus.core_ctrl[1] = 2'd0;
        cyc();
        reset = 1'b0;
        compared++;
        if (bus.ram_rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.core_done !== '0 || bus.core_instr !== '0) begin
            mismatched++;
            $display("FAIL rmid_cleared rd_en=%b busy=%b done=%h instr1=%h expected 0/0/0000/0000",
                     bus.ram_rd_en, bus.busy, bus.core_done, bus.core_instr[1]);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            compared++;
            if (bus.core_done !== '0 || bus.core_instr !== '0) begin
                mismatched++;
                $display("FAIL rmid_quiet_%0d done=%h instr1=%h expected 0000/0000", c, bus.core_done, bus.core_instr[1]);
            end
        end
        bus.core_ctrl[2] = 2'd1;
        bus.core_addr[2] = 16'h0032;
        push(2, 16'h3232);
        cyc();
        compared++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_addr !== 16'h0032) begin
            mismatched++;
            $display("FAIL rmid_regrant rd_en=%b addr=%h expected 1/0032", bus.ram_rd_en, bus.ram_addr);
        end
        bus.core_ctrl[2] = 2'd0;
        repeat (3) cyc();
        compared++;
        if (sb.size() != 0 || bus.core_instr[2] !== 16'h3232) begin
            mismatched++;
            $display("FAIL rmid_drain pending=%0d instr2=%h expected 0/3232", sb.size(), bus.core_instr[2]);
        end
    endtask

    task automatic test_drop_and_perf();
        do_reset();
        mem[8'h44] = 16'h4444;
        mem[8'h55] = 16'h5555;
        mem[8'h66] = 16'h6666;
        bus.core_ctrl[4] = 2'd1;
        bus.core_addr[4] = 16'h0044;
        push(4, 16'h4444);
        cyc();
        bus.core_ctrl[4] = 2'd0;
        bus.core_addr[4] = 16'h0099;
        cyc();
        cyc();
        compared++;
        if (bus.core_done !== 16'h0010 || bus.core_instr[4] !== 16'h4444) begin
            mismatched++;
            $display("FAIL drop_done done=%h instr=%h expected 0010/4444", bus.core_done, bus.core_instr[4]);
        end
        cyc();
        do_reset();
        bus.core_ctrl[5] = 2'd1;
        bus.core_addr[5] = 16'h0055;
        bus.core_ctrl[6] = 2'd1;
        bus.core_addr[6] = 16'h0066;
        push(5, 16'h5555);
        push(6, 16'h6666);
        cyc();
        compared++;
        if (bus.ram_addr !== 16'h0055 || bus.ram_rd_en !== 1'b1) begin
            mismatched++;
            $display("FAIL pair_first rd_en=%b addr=%h expected 1/0055", bus.ram_rd_en, bus.ram_addr);
        end
        bus.core_ctrl[5] = 2'd0;
        cyc();
        compared++;
        if (bus.ram_addr !== 16'h0066 || bus.ram_rd_en !== 1'b1) begin
            mismatched++;
            $display("FAIL pair_second rd_en=%b addr=%h expected 1/0066", bus.ram_rd_en, bus.ram_addr);
        end
        bus.core_ctrl[6] = 2'd0;
        repeat (3) cyc();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL pair_drain pending=%0d expected 0", sb.size());
        end
`ifdef IFETCH_PERF_EN
        compared++;
        if (bus.perf_fetches !== 32'd2 || bus.perf_stalls !== 32'd1) begin
            mismatched++;
            $display("FAIL perf_counts fetches=%0d stalls=%0d expected 2/1", bus.perf_fetches, bus.perf_stalls);
        end
`endif
    endtask

    initial begin
        bus.core_ctrl = '0;
        bus.core_addr = '0;
        bus.ram_rdata = '0;
        test_reset();
        test_single();
        test_all_cores();
        test_rotation();
        test_back_to_back();
        test_reset_mid();
        test_drop_and_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/iram_fetch_arbiter.md
Name: iram_fetch_arbiter

Overview:
- Shares one registered read port of the instruction RAM among NUM_CORES processing cores.
- Each core posts a fetch request and receives its instruction word with a one-cycle done pulse.
- Round-robin arbitration; one grant per cycle; fully pipelined for up to one fetch per cycle.
- Sits between the per-core fetch stages and the instruction RAM. Control encoding 2'd1 = read IRAM.

Parameters:
- NUM_CORES, 16, number of requesting cores (2..16)
- ADDR_W, 16, instruction address width
- DATA_W, 16, instruction word width
- RAM_LATENCY, 1, cycles from ram_rd_en/ram_addr sampled by the RAM to ram_rdata valid (1..3)

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- core_ctrl  in  2*NUM_CORES  per-core control, slice i = [2i+1:2i]; 2'd1 = fetch request, other values = no request
- core_addr  in  ADDR_W*NUM_CORES  per-core fetch address, slice i
- core_instr  out  DATA_W*NUM_CORES  per-core registered instruction word, slice i
- core_done  out  NUM_CORES  one-cycle pulse: core_instr slice i just updated
- ram_rd_en  out  1  registered RAM read strobe
- ram_addr  out  ADDR_W  registered RAM read address
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high while any fetch is in flight

Behaviour:
- Reset: every output, including core_instr, goes to 0. RR pointer = 0, in-flight mask = 0, return pipeline cleared.
- Eligibility per edge: core i is eligible when core_ctrl slice i == 2'd1 and inflight[i] == 0.
- Arbitration: at each edge, grant the first eligible core searching from ptr upward, modulo NUM_CORES.
  - On a grant: ptr <= granted+1 (wrap to 0), inflight[g] <= 1, ram_rd_en <= 1, ram_addr <= core_addr slice g.
  - No eligible core: ram_rd_en <= 0, ram_addr holds, ptr holds.
- Return pipeline: the granted core ID and a valid bit shift through 1+RAM_LATENCY stages.
  - When the last stage is valid at edge Ec: core_instr[id] <= ram_rdata, core_done[id] <= 1 for exactly one cycle, inflight[id] <= 0.
- Timing (RAM_LATENCY=1, uncontended):
  - Request sampled at E0; ram_rd_en high after E0; data captured at E2; core_done high in cycle E2..E3.
  - Same core re-requesting with a new address is first eligible at E3.
  - Eligibility at E2 uses the pre-update mask, so a stale held request is never double-granted.
- Throughput: one grant per cycle. Several cores may be in flight at once; at most one core_done bit is set per cycle.
- Request dropped while in flight: the fetch still completes, and core_instr and core_done update normally.
- Address change while in flight: ignored; the address is captured at grant.
- core_instr slice i holds its value except on that core's capture.
- busy = OR of inflight, registered, so it follows the mask update.
- Reset mid-operation: in-flight fetches are discarded, no done pulses are issued, and RAM data arriving after reset is ignored.
- Non-power-of-2 NUM_CORES: ptr wraps explicitly at NUM_CORES-1.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: add outputs perf_fetches (32 bits) and perf_stalls (32 bits), both cleared by reset.
  - perf_fetches increments per grant.
  - perf_stalls increments per edge where at least one core has core_ctrl == 2'd1 and inflight == 0 but is not granted.
  - Both saturate at all-ones.
- Undefined: the outputs and counters are absent; all other behaviour is identical.

Test Plan:
- Single core, RAM model ram[5]=16'h4008. Core 3 ctrl=2'd1, addr=5 sampled at E0 -> ram_rd_en=1, ram_addr=5 after E0; core_instr[3]=16'h4008 and core_done=16'h0008 for one cycle after E2; busy falls after E2.
- All 16 cores request at once from reset, addr=i (ram[i]=i+16'h100) -> grants in order 0..15 on consecutive edges; each core gets done exactly once with instr=i+16'h100; no duplicate grants.
- Rotation: ptr=14, cores 2, 14 and 15 request -> grant order 14, 15, 2.
- Core 7 holds ctrl=2'd1 continuously, addr 9 then 10 after its done -> exactly two fetches, 3 edges apart (RAM_LATENCY=1); no fetch of addr 9 is issued twice.
- Reset asserted one cycle after a grant to core 1 -> no core_done pulse, core_instr all 0, ram_rd_en=0; the next request is granted normally.
- Core 4 ctrl changes to 2'd0 in the cycle after its grant -> done still pulses with the correct data. With IFETCH_PERF_EN and 2 simultaneous requests: perf_fetches=2, perf_stalls=1.
